// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer: state encoding and the
// active-low gfedcba seven-segment glyph table (digits 0-9, then blank).
package timer_pkg;

  typedef enum logic [1:0] {
    ST_SET  = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } timer_state_e;

  localparam int SEG_BLANK_IDX = 10;

  // Entry i is the glyph for digit i; entry 10 is blank.
  localparam logic [10:0][6:0] SEG_TABLE = {
    7'b1111111,
    7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
    7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

endpackage

// File: rtl/led7_decoder.sv
// One BCD digit to an active-low seven-segment pattern; non-decimal codes blank.
module led7_decoder
  import timer_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_TABLE[SEG_BLANK_IDX];
    if (digit <= 4'd9) seg = SEG_TABLE[digit];
  end

endmodule

// File: rtl/tick_divider.sv
// Divides clk down to a one-cycle tick strobe; clr has priority and the count
// simply holds while en is low, so a pause never loses or gains a tick.
module tick_divider #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] TERM = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == TERM) begin
        cnt_d = '0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/countdown_timer_param.sv
// Settable countdown timer: buttons load a preset in SET, RUN counts down once
// per tick, with BCD / seven-segment display outputs and an expiry pulse.
module countdown_timer_param
  import timer_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int TICK_HZ     = 1,
  parameter int MAX_VAL     = 59,
  parameter int DIGITS      = 2,
  parameter int AUTO_RELOAD = 0,
  localparam int W          = $clog2(MAX_VAL + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mode,
  input  logic                add_n,
  input  logic                deduct_n,
  input  logic                pause,
  output logic [W-1:0]        value,
  output logic [4*DIGITS-1:0] bcd,
  output logic [7*DIGITS-1:0] seg,
  output logic                trigger,
  output logic                expired,
  output timer_state_e        dbg_state
);

  localparam logic [W-1:0] MAX_W = W'(MAX_VAL);

  // Each input: [0],[1] two-flop synchroniser, [2] previous synchronised level.
  logic [2:0] mode_sr_q, mode_sr_d;
  logic [2:0] add_sr_q, add_sr_d;
  logic [2:0] ded_sr_q, ded_sr_d;

  timer_state_e state_q, state_d;
  logic [W-1:0] preset_q, preset_d;
  logic [W-1:0] value_q, value_d;
  logic         expired_q, expired_d;

  logic mode_rise, mode_fall, add_edge, ded_edge;
  logic div_en, div_clr, tick;

  always_comb begin
    mode_sr_d = {mode_sr_q[1:0], mode};
    add_sr_d  = {add_sr_q[1:0], add_n};
    ded_sr_d  = {ded_sr_q[1:0], deduct_n};
  end

  assign mode_rise = ~mode_sr_q[2] &  mode_sr_q[1];
  assign mode_fall =  mode_sr_q[2] & ~mode_sr_q[1];
  assign add_edge  =  add_sr_q[2]  & ~add_sr_q[1];
  assign ded_edge  =  ded_sr_q[2]  & ~ded_sr_q[1];

  assign div_en  = (state_q == ST_RUN) && !pause;
  assign div_clr = (state_q != ST_RUN);

  tick_divider #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ)
  ) u_tick_divider (
    .clk  (clk),
    .rst  (rst),
    .en   (div_en),
    .clr  (div_clr),
    .tick (tick)
  );

  always_comb begin
    state_d   = state_q;
    preset_d  = preset_q;
    value_d   = value_q;
    expired_d = 1'b0;
    if (mode_rise) begin
      state_d = ST_SET;
      value_d = preset_q;
    end else begin
      case (state_q)
        ST_SET: begin
          if (add_edge && !ded_edge)
            preset_d = (preset_q == MAX_W) ? '0 : preset_q + 1'b1;
          else if (ded_edge && !add_edge)
            preset_d = (preset_q == '0) ? MAX_W : preset_q - 1'b1;
          value_d = preset_d;
          if (mode_fall) state_d = (preset_d == '0) ? ST_DONE : ST_RUN;
        end
        ST_RUN: begin
          if (tick) begin
            // A zero value in RUN only survives under auto-reload: reload now.
            if (value_q == '0) begin
              value_d = preset_q;
            end else begin
              value_d = value_q - 1'b1;
              if (value_q == W'(1)) begin
                expired_d = 1'b1;
                if (AUTO_RELOAD == 0 || preset_q == '0) state_d = ST_DONE;
              end
            end
          end
        end
        ST_DONE: value_d = '0;
        default: state_d = ST_SET;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_sr_q <= 3'b111;
      add_sr_q  <= 3'b111;
      ded_sr_q  <= 3'b111;
      state_q   <= ST_SET;
      preset_q  <= '0;
      value_q   <= '0;
      expired_q <= 1'b0;
    end else begin
      mode_sr_q <= mode_sr_d;
      add_sr_q  <= add_sr_d;
      ded_sr_q  <= ded_sr_d;
      state_q   <= state_d;
      preset_q  <= preset_d;
      value_q   <= value_d;
      expired_q <= expired_d;
    end
  end

  function automatic logic [4*DIGITS-1:0] to_bcd(input logic [W-1:0] bin);
    logic [4*DIGITS-1:0] acc;
    acc = '0;
    for (int i = W - 1; i >= 0; i--) begin
      for (int d = 0; d < DIGITS; d++) begin
        if (acc[4*d +: 4] >= 4'd5) acc[4*d +: 4] = acc[4*d +: 4] + 4'd3;
      end
      acc = {acc[4*DIGITS-2:0], bin[i]};
    end
    return acc;
  endfunction

  assign bcd = to_bcd(value_q);

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    led7_decoder u_led7_decoder (
      .digit (bcd[4*g +: 4]),
      .seg   (seg[7*g +: 7])
    );
  end

  assign value     = value_q;
  assign trigger   = (value_q == '0);
  assign expired   = expired_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_countdown_timer_param.sv
// Bench for countdown_timer_param: instance a stops in DONE, instance b auto-reloads.
module tb_countdown_timer_param;
  import timer_pkg::*;

  typedef struct packed {
    logic [5:0]  value;
    logic        expired;
    logic        trigger;
    logic [7:0]  bcd;
    logic [13:0] seg;
    logic [31:0] at;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic mode_a, add_n_a, deduct_n_a, pause_a;
  logic mode_b, add_n_b, deduct_n_b, pause_b;
  logic [5:0]  value_a, value_b;
  logic [7:0]  bcd_a, bcd_b;
  logic [13:0] seg_a, seg_b;
  logic        trigger_a, trigger_b, expired_a, expired_b;
  timer_state_e state_a, state_b;

  exp_t exp_a_q[$];
  exp_t exp_b_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int xp_a = 0, xp_b = 0;
  logic mon_en = 1'b0;
  int c;

  countdown_timer_param #(.CLK_HZ(10), .TICK_HZ(1), .MAX_VAL(59), .DIGITS(2), .AUTO_RELOAD(0)) dut_a (
    .clk(clk), .rst(rst), .mode(mode_a), .add_n(add_n_a), .deduct_n(deduct_n_a), .pause(pause_a),
    .value(value_a), .bcd(bcd_a), .seg(seg_a), .trigger(trigger_a), .expired(expired_a),
    .dbg_state(state_a)
  );

  countdown_timer_param #(.CLK_HZ(10), .TICK_HZ(1), .MAX_VAL(59), .DIGITS(2), .AUTO_RELOAD(1)) dut_b (
    .clk(clk), .rst(rst), .mode(mode_b), .add_n(add_n_b), .deduct_n(deduct_n_b), .pause(pause_b),
    .value(value_b), .bcd(bcd_b), .seg(seg_b), .trigger(trigger_b), .expired(expired_b),
    .dbg_state(state_b)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- reference helpers ----------------
  function automatic logic [6:0] seg_ref(input int d);
    case (d)
      0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
      3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
      9: return 7'b0010000;  default: return 7'b1111111;
    endcase
  endfunction

  function automatic exp_t mk(input int v, input logic ex, input int at);
    exp_t e;
    e.value   = 6'(v);
    e.expired = ex;
    e.trigger = (v == 0);
    e.bcd     = {4'(v / 10), 4'(v % 10)};
    e.seg     = {seg_ref(v / 10), seg_ref(v % 10)};
    e.at      = 32'(at);
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic compare(input string tag, input exp_t e, input logic [5:0] v, input logic ex,
                         input logic tr, input logic [7:0] b, input logic [13:0] s);
    check({tag, "_value"}, 32'(v), 32'(e.value));
    check({tag, "_expired"}, 32'(ex), 32'(e.expired));
    check({tag, "_trigger"}, 32'(tr), 32'(e.trigger));
    check({tag, "_bcd"}, 32'(b), 32'(e.bcd));
    check({tag, "_seg"}, 32'(s), 32'(e.seg));
    check({tag, "_cycle"}, 32'(cyc), e.at);
  endtask

  // ---------------- scoreboard monitors ----------------
  initial begin
    logic [5:0] prev_a;
    exp_t ea;
    prev_a = '0;
    forever begin
      @(negedge clk);
      if (mon_en && value_a !== prev_a) begin
        if (exp_a_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL a_unexpected_change: got %0d, expected no change from %0d (cycle %0d)",
                   value_a, prev_a, cyc);
        end else begin
          ea = exp_a_q.pop_front();
          compare("a", ea, value_a, expired_a, trigger_a, bcd_a, seg_a);
        end
      end
      prev_a = value_a;
    end
  end

  initial begin
    logic [5:0] prev_b;
    exp_t eb;
    prev_b = '0;
    forever begin
      @(negedge clk);
      if (mon_en && value_b !== prev_b) begin
        if (exp_b_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_unexpected_change: got %0d, expected no change from %0d (cycle %0d)",
                   value_b, prev_b, cyc);
        end else begin
          eb = exp_b_q.pop_front();
          compare("b", eb, value_b, expired_b, trigger_b, bcd_b, seg_b);
        end
      end
      prev_b = value_b;
    end
  end

  // Expiry pulse width and count.
  initial begin
    int wa, wb;
    wa = 0; wb = 0;
    forever begin
      @(negedge clk);
      if (expired_a === 1'b1) wa++;
      else if (wa != 0) begin check("a_expired_width", 32'(wa), 32'd1); xp_a++; wa = 0; end
      if (expired_b === 1'b1) wb++;
      else if (wb != 0) begin check("b_expired_width", 32'(wb), 32'd1); xp_b++; wb = 0; end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Press one or both buttons; a change is expected 3 clocks after the press.
  task automatic press(input bit on_b, input bit a, input bit d, input int v, input bit chg);
    int c0;
    c0 = cyc;
    if (chg) begin
      if (on_b) exp_b_q.push_back(mk(v, 1'b0, c0 + 3));
      else      exp_a_q.push_back(mk(v, 1'b0, c0 + 3));
    end
    if (on_b) begin add_n_b = ~a; deduct_n_b = ~d; end
    else      begin add_n_a = ~a; deduct_n_a = ~d; end
    step(2);
    add_n_a = 1'b1; deduct_n_a = 1'b1; add_n_b = 1'b1; deduct_n_b = 1'b1;
    step(4);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    mode_a = 1'b1; add_n_a = 1'b1; deduct_n_a = 1'b1; pause_a = 1'b0;
    mode_b = 1'b1; add_n_b = 1'b1; deduct_n_b = 1'b1; pause_b = 1'b0;
    step(2);
    rst = 1'b0;
    step(1);

    check("rst_value", 32'(value_a), 32'd0);
    check("rst_trigger", 32'(trigger_a), 32'd1);
    check("rst_expired", 32'(expired_a), 32'd0);
    check("rst_seg", 32'(seg_a), 32'({7'b1000000, 7'b1000000}));
    check("rst_bcd", 32'(bcd_a), 32'd0);
    check("rst_state", 32'(state_a), 32'(ST_SET));
    check("rst_value_b", 32'(value_b), 32'd0);
    mon_en = 1'b1;

    // SET-mode editing, wrap at both ends, both buttons together.
    press(0, 1, 0, 1, 1);  press(0, 1, 0, 2, 1);  press(0, 1, 0, 3, 1);
    press(0, 0, 1, 2, 1);  press(0, 0, 1, 1, 1);  press(0, 0, 1, 0, 1);
    press(0, 0, 1, 59, 1); press(0, 1, 0, 0, 1);
    press(0, 1, 1, 0, 0);
    check("set_both_buttons", 32'(value_a), 32'd0);
    press(0, 1, 0, 1, 1);  press(0, 1, 0, 2, 1);  press(0, 1, 0, 3, 1);

    // Countdown from 3 without reload.
    c = cyc;
    exp_a_q.push_back(mk(2, 1'b0, c + 13));
    exp_a_q.push_back(mk(1, 1'b0, c + 23));
    exp_a_q.push_back(mk(0, 1'b1, c + 33));
    mode_a = 1'b0;
    step(3);
    check("run_state", 32'(state_a), 32'(ST_RUN));
    press(0, 1, 0, 0, 0);
    step(54);
    check("done_state", 32'(state_a), 32'(ST_DONE));
    check("done_value", 32'(value_a), 32'd0);

    // Back to SET: preset 3 is shown again.
    c = cyc;
    exp_a_q.push_back(mk(3, 1'b0, c + 3));
    mode_a = 1'b1;
    step(6);
    check("reenter_set_state", 32'(state_a), 32'(ST_SET));
    press(0, 1, 0, 4, 1);  press(0, 1, 0, 5, 1);  press(0, 1, 0, 6, 1);  press(0, 1, 0, 7, 1);

    // Run from 7, pause for 25 clocks at value 5, then reset at value 4.
    c = cyc;
    exp_a_q.push_back(mk(6, 1'b0, c + 13));
    exp_a_q.push_back(mk(5, 1'b0, c + 23));
    exp_a_q.push_back(mk(4, 1'b0, c + 58));
    mode_a = 1'b0;
    step(26);
    pause_a = 1'b1;
    step(19);
    check("pause_frozen", 32'(value_a), 32'd5);
    step(6);
    pause_a = 1'b0;
    step(9);
    exp_a_q.push_back(mk(0, 1'b0, cyc + 1));
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("midrun_rst_state", 32'(state_a), 32'(ST_SET));
    check("midrun_rst_value", 32'(value_a), 32'd0);
    step(4);
    check("zero_preset_done", 32'(state_a), 32'(ST_DONE));
    check("zero_preset_no_expired", 32'(xp_a), 32'd1);
    mode_a = 1'b1;
    step(6);
    press(0, 1, 0, 1, 1);

    // Auto-reload instance: preset 2 gives 2,1,0,2,1,0.
    press(1, 1, 0, 1, 1);  press(1, 1, 0, 2, 1);
    c = cyc;
    exp_b_q.push_back(mk(1, 1'b0, c + 13));
    exp_b_q.push_back(mk(0, 1'b1, c + 23));
    exp_b_q.push_back(mk(2, 1'b0, c + 33));
    exp_b_q.push_back(mk(1, 1'b0, c + 43));
    exp_b_q.push_back(mk(0, 1'b1, c + 53));
    mode_b = 1'b0;
    step(55);
    check("reload_still_run", 32'(state_b), 32'(ST_RUN));
    c = cyc;
    exp_b_q.push_back(mk(2, 1'b0, c + 3));
    mode_b = 1'b1;
    step(6);
    check("reload_back_to_set", 32'(state_b), 32'(ST_SET));

    step(5);
    check("a_queue_drained", 32'(exp_a_q.size()), 32'd0);
    check("b_queue_drained", 32'(exp_b_q.size()), 32'd0);
    check("a_expired_pulses", 32'(xp_a), 32'd1);
    check("b_expired_pulses", 32'(xp_b), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    checks++; errors++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
